// File: rtl/adc_packet_framer_pkg.sv
// Shared state encodings and constants for the ADC packet framer.
// Main FSM and handshake phases are kept as plain localparams for legacy tools.
package adc_framer_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HEADER   = 3'd1,
    S_LENGTH   = 3'd2,
    S_DATA     = 3'd3,
    S_CHECKSUM = 3'd4
  } main_state_e;

  typedef enum logic [1:0] {
    P_ISSUE     = 2'd0,
    P_WAIT_BUSY = 2'd1,
    P_WAIT_IDLE = 2'd2
  } hs_phase_e;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  localparam logic [2:0] ST_IDLE     = S_IDLE;
  localparam logic [2:0] ST_HEADER   = S_HEADER;
  localparam logic [2:0] ST_LENGTH   = S_LENGTH;
  localparam logic [2:0] ST_DATA     = S_DATA;
  localparam logic [2:0] ST_CHECKSUM = S_CHECKSUM;

  localparam logic [1:0] PH_ISSUE     = P_ISSUE;
  localparam logic [1:0] PH_WAIT_BUSY = P_WAIT_BUSY;
  localparam logic [1:0] PH_WAIT_IDLE = P_WAIT_IDLE;

endpackage

// File: rtl/adc_packet_framer_if.sv
// Framer-side signal bundle: trigger, FWFT sample FIFO and UART ADC streaming path.
// master = the framer, slave = the surrounding FIFO / UART wrapper.
interface adc_packet_framer_if;
  logic       Trigger;
  logic [7:0] SampleData;
  logic       SampleEmpty;
  logic       SampleRead;
  logic       TxStrobe;
  logic [7:0] TxData;
  logic       TxValid;
  logic       Streaming;
  logic       PacketDone;
  logic       Overrun;

  modport master (
    input  Trigger, SampleData, SampleEmpty, TxStrobe,
    output SampleRead, TxData, TxValid, Streaming, PacketDone, Overrun
  );

  modport slave (
    output Trigger, SampleData, SampleEmpty, TxStrobe,
    input  SampleRead, TxData, TxValid, Streaming, PacketDone, Overrun
  );
endinterface

// File: rtl/adc_packet_framer_tx_byte_handshake.sv
// One-byte transfer to the UART: issue on idle strobe, wait for busy, wait for idle.
// accepted_o pulses on the issue cycle, done_o when the UART is idle again.
module tx_byte_handshake
  import adc_framer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  input  logic [7:0] byte_i,
  input  logic       strobe_i,
  output logic       tx_valid_o,
  output logic [7:0] tx_data_o,
  output logic       accepted_o,
  output logic       done_o
);

  logic [1:0] phase_q, phase_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;

  always_comb begin
    phase_d    = phase_q;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    accepted_o = 1'b0;
    done_o     = 1'b0;
    case (phase_q)
      PH_ISSUE: begin
        if (req_i && strobe_i) begin
          accepted_o = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = byte_i;
          phase_d    = PH_WAIT_BUSY;
        end
      end
      PH_WAIT_BUSY: if (!strobe_i) phase_d = PH_WAIT_IDLE;
      PH_WAIT_IDLE: begin
        if (strobe_i) begin
          done_o  = 1'b1;
          phase_d = PH_ISSUE;
        end
      end
      default: phase_d = PH_ISSUE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q    <= PH_ISSUE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      phase_q    <= phase_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;

endmodule

// File: rtl/adc_packet_framer.sv
// Drains PKT_LEN FIFO samples per trigger into a header/length/data[/checksum] packet.
// Define ADC_FRAMER_CHECKSUM_EN to append the two's-complement checksum byte.
module adc_packet_framer
  import adc_framer_pkg::*;
#(
  parameter int         PKT_LEN = 16,
  parameter logic [7:0] HEADER  = HEADER_DEFAULT
) (
  input  logic                Clock,
  input  logic                Reset,
  adc_packet_framer_if.master bus
);

  localparam logic [7:0] LEN_BYTE = 8'(PKT_LEN);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       overrun_q, overrun_d;
  logic       done_q, done_d;
  logic       streaming_q, streaming_d;
  logic       hs_req, hs_accepted, hs_done, last_sample;
  logic [7:0] byte_sel;
`ifdef ADC_FRAMER_CHECKSUM_EN
  logic [7:0] acc_q, acc_d;
`endif

  assign last_sample = (cnt_q == LEN_BYTE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    done_d    = 1'b0;
    byte_sel  = HEADER;
    hs_req    = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_HEADER: begin
        hs_req = 1'b1;
        if (hs_done) state_d = ST_LENGTH;
      end
      ST_LENGTH: begin
        byte_sel = LEN_BYTE;
        hs_req   = 1'b1;
        if (hs_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        byte_sel = bus.SampleData;
        // An empty FIFO simply withholds the request, stalling in the issue phase.
        hs_req   = !bus.SampleEmpty && !last_sample;
        if (hs_accepted) cnt_d = cnt_q + 8'd1;
        if (hs_done && last_sample) begin
`ifdef ADC_FRAMER_CHECKSUM_EN
          state_d = ST_CHECKSUM;
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef ADC_FRAMER_CHECKSUM_EN
      ST_CHECKSUM: begin
        byte_sel = 8'd0 - acc_q;
        hs_req   = 1'b1;
        if (hs_done) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (bus.Trigger) begin
      if (state_q == ST_IDLE) begin
        state_d   = ST_HEADER;
        cnt_d     = 8'd0;
        overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end
    streaming_d = (state_d != ST_IDLE);
  end

`ifdef ADC_FRAMER_CHECKSUM_EN
  // Header is deliberately excluded from the running sum.
  always_comb begin
    acc_d = acc_q;
    if (bus.Trigger && state_q == ST_IDLE)
      acc_d = 8'd0;
    else if (hs_accepted && (state_q == ST_LENGTH || state_q == ST_DATA))
      acc_d = acc_q + byte_sel;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) acc_q <= 8'd0;
    else        acc_q <= acc_d;
  end
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
      streaming_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      overrun_q   <= overrun_d;
      done_q      <= done_d;
      streaming_q <= streaming_d;
    end
  end

  tx_byte_handshake u_hs (
    .clk_i      (Clock),
    .rst_ni     (Reset),
    .req_i      (hs_req),
    .byte_i     (byte_sel),
    .strobe_i   (bus.TxStrobe),
    .tx_valid_o (bus.TxValid),
    .tx_data_o  (bus.TxData),
    .accepted_o (hs_accepted),
    .done_o     (hs_done)
  );

  assign bus.SampleRead = hs_accepted && (state_q == ST_DATA);
  assign bus.Streaming  = streaming_q;
  assign bus.PacketDone = done_q;
  assign bus.Overrun    = overrun_q;

endmodule

// File: tb/tb_adc_packet_framer.sv
// Directed bench for adc_packet_framer (PKT_LEN=4) with a FWFT FIFO model and a
// UART model that stays busy for 10 cycles after each TxValid.
module tb_adc_packet_framer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc_packet_framer_if bus ();

  adc_packet_framer #(.PKT_LEN(4), .HEADER(8'hA5)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;

  // FIFO model: main pushes, monitor pops one negedge after the edge that consumed.
  logic [7:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.SampleData  = fifo_mem[rd_ptr[5:0]];
  assign bus.SampleEmpty = (rd_ptr == wr_ptr);

  int busy = 0;
  bit hold = 1'b0;
  assign bus.TxStrobe = !hold && (busy == 0);

  logic [7:0] wire_q [$];
  int  rd_cnt = 0, done_cnt = 0, tx_cnt = 0, b2b = 0, low_at_done = 0;
  bit  rd_pending = 1'b0, prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rd_pending) rd_ptr++;
    rd_pending = bus.SampleRead;
    if (bus.SampleRead) rd_cnt++;
    if (bus.TxValid) begin
      wire_q.push_back(bus.TxData);
      tx_cnt++;
      busy = 10;
    end else if (busy > 0) begin
      busy--;
    end
    if (bus.TxValid && prev_valid) b2b++;
    prev_valid = bus.TxValid;
    if (bus.PacketDone) begin
      done_cnt++;
      if (!bus.Streaming) low_at_done++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_trigger();
    bus.Trigger = 1'b1;
    @(negedge clk);
    bus.Trigger = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[5:0]] = b;
    wr_ptr++;
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done_cnt, target);
  endtask

  task automatic wait_rd(input int target, input string tag);
    int n = 0;
    while (rd_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, rd_cnt, target);
  endtask

  // exp holds the wire bytes left-aligned: byte i is exp[55-8*i -: 8].
  task automatic check_packet(input string tag, input int base, input logic [55:0] exp);
    int nbytes;
    logic [7:0] obs;
`ifdef ADC_FRAMER_CHECKSUM_EN
    nbytes = 7;
`else
    nbytes = 6;
`endif
    chk({tag, "_len"}, wire_q.size() - base, nbytes);
    for (int i = 0; i < nbytes; i++) begin
      obs = (base + i < wire_q.size()) ? wire_q[base + i] : 8'hxx;
      chk($sformatf("%s_b%0d", tag, i), obs, exp[55 - 8*i -: 8]);
    end
  endtask

  initial begin
    int base, rd0, d0, t0, low_cnt, tv_cnt;
    bus.Trigger = 1'b0;
    for (int i = 0; i < 64; i++) fifo_mem[i] = 8'h00;

    // Reset state
    tick(3);
    chk("rst_txdata", bus.TxData, 8'h00);
    chk("rst_txvalid", bus.TxValid, 1'b0);
    chk("rst_streaming", bus.Streaming, 1'b0);
    chk("rst_sampleread", bus.SampleRead, 1'b0);
    chk("rst_packetdone", bus.PacketDone, 1'b0);
    chk("rst_overrun", bus.Overrun, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // Basic packet, also checks trigger-to-header latency
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    base = wire_q.size(); rd0 = rd_cnt; d0 = done_cnt;
    pulse_trigger();
    chk("basic_stream_n1", bus.Streaming, 1'b1);
    chk("basic_valid_n1", bus.TxValid, 1'b0);
    tick(1);
    chk("basic_hdr_valid", bus.TxValid, 1'b1);
    chk("basic_hdr_data", bus.TxData, 8'hA5);
    wait_done(d0 + 1, "basic_done");
    tick(5);
    check_packet("basic", base, 56'hA5_04_01_02_03_04_F2);
    chk("basic_reads", rd_cnt - rd0, 4);
    chk("basic_done_cnt", done_cnt - d0, 1);
    chk("basic_stream_low_at_done", low_at_done, 1);
    chk("basic_stream_idle", bus.Streaming, 1'b0);

    // Mid-packet stall: FIFO holds only two samples for 50 cycles
    push(8'h10); push(8'h20);
    base = wire_q.size(); rd0 = rd_cnt; d0 = done_cnt;
    pulse_trigger();
    wait_rd(rd0 + 2, "stall_first2");
    tick(1);
    t0 = tx_cnt; low_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.Streaming) low_cnt++;
    end
    chk("stall_no_txvalid", tx_cnt - t0, 0);
    chk("stall_stream_high", low_cnt, 0);
    chk("stall_no_read", rd_cnt - rd0, 2);
    push(8'h30); push(8'h40);
    wait_done(d0 + 1, "stall_done");
    tick(5);
    check_packet("stall", base, 56'hA5_04_10_20_30_40_5C);

    // Trigger during DATA sets Overrun; next accepted trigger clears it
    push(8'hFF); push(8'h80); push(8'h01); push(8'h7F);
    base = wire_q.size(); rd0 = rd_cnt; d0 = done_cnt;
    pulse_trigger();
    wait_rd(rd0 + 1, "ovr_in_data");
    pulse_trigger();
    chk("ovr_set", bus.Overrun, 1'b1);
    wait_done(d0 + 1, "ovr_done");
    tick(30);
    chk("ovr_one_packet", done_cnt - d0, 1);
    chk("ovr_sticky", bus.Overrun, 1'b1);
    check_packet("ovr", base, 56'hA5_04_FF_80_01_7F_FD);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    base = wire_q.size(); d0 = done_cnt;
    pulse_trigger();
    chk("ovr_cleared", bus.Overrun, 1'b0);
    wait_done(d0 + 1, "ovr2_done");
    tick(5);
    check_packet("ovr2", base, 56'hA5_04_11_22_33_44_52);

    // Reset while the length byte is in flight
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    t0 = tx_cnt; rd0 = rd_cnt;
    pulse_trigger();
    for (int n = 0; n < 200 && tx_cnt < t0 + 2; n++) @(negedge clk);
    chk("rstlen_reached", tx_cnt - t0, 2);
    rst_n = 1'b0;
    #1;
    chk("rstlen_txvalid", bus.TxValid, 1'b0);
    chk("rstlen_txdata", bus.TxData, 8'h00);
    chk("rstlen_streaming", bus.Streaming, 1'b0);
    chk("rstlen_sampleread", bus.SampleRead, 1'b0);
    chk("rstlen_packetdone", bus.PacketDone, 1'b0);
    chk("rstlen_no_samples", rd_cnt - rd0, 0);
    tick(2);
    rst_n = 1'b1;
    tick(15);
    base = wire_q.size(); d0 = done_cnt;
    pulse_trigger();
    wait_done(d0 + 1, "rstlen_done");
    tick(5);
    check_packet("rstlen", base, 56'hA5_04_01_02_03_04_F2);

    // UART busy at trigger: header waits for TxStrobe to rise
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    hold = 1'b1;
    tick(2);
    base = wire_q.size(); d0 = done_cnt; tv_cnt = 0;
    pulse_trigger();
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (bus.TxValid) tv_cnt++;
    end
    chk("busy_no_hdr", tv_cnt, 0);
    chk("busy_stream", bus.Streaming, 1'b1);
    hold = 1'b0;
    @(negedge clk);
    chk("busy_hdr_valid", bus.TxValid, 1'b1);
    chk("busy_hdr_data", bus.TxData, 8'hA5);
    wait_done(d0 + 1, "busy_done");
    tick(5);
    check_packet("busy", base, 56'hA5_04_01_02_03_04_F2);

    chk("no_back_to_back_valid", b2b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_packet_framer.md
# adc_packet_framer

Packetizing stage directly upstream of the UART transmit wrapper. On a trigger it drains a fixed number of 8-bit samples from the first-word-fall-through ADC sample FIFO and emits a framed packet: header, length, samples, and an optional checksum. Bytes are delivered one at a time through the wrapper's ADC streaming path (`ADCData` / `adcDataValid` / `adcDataStrobe` / `adcDataStreamingMode`). The block owns the streaming-mode select for the whole packet, so general UART traffic is held off until the packet is complete.

## Interface
Parameters:
- `PKT_LEN`, 16: samples per packet, legal range 1..255; also the value sent in the length byte.
- `HEADER`, 8'hA5: first byte of every packet.

Ports (one clock; reset is asynchronous and active-low):
- `Clock`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `Trigger`  in  1  single-cycle request to send one packet.
- `SampleData`  in  8  FIFO head word (FWFT).
- `SampleEmpty`  in  1  FIFO empty.
- `SampleRead`  out  1  FIFO pop; one cycle per sample consumed.
- `TxStrobe`  in  1  UART idle indication; connects to `adcDataStrobe`.
- `TxData`  out  8  byte to transmit; connects to `ADCData`.
- `TxValid`  out  1  one-cycle transmit start; connects to `adcDataValid`.
- `Streaming`  out  1  high for the whole packet; connects to `adcDataStreamingMode`.
- `PacketDone`  out  1  one-cycle pulse after the last byte is accepted by the UART.
- `Overrun`  out  1  sticky flag: a trigger arrived while a packet was in progress.

## Operation
- Main FSM states: IDLE → HEADER → LENGTH → DATA → CHECKSUM → IDLE.
  - Without the checksum feature, DATA goes directly to IDLE.
- Each byte state runs a three-phase handshake:
  - ISSUE: wait for `TxStrobe`=1 and a byte being available. On the qualifying edge, load `TxData` and drive `TxValid`=1 for exactly one cycle.
  - WAIT_BUSY: wait for `TxStrobe`=0.
  - WAIT_IDLE: wait for `TxStrobe`=1, then advance to the next byte state.
- Byte availability:
  - HEADER, LENGTH and CHECKSUM bytes are always available.
  - A DATA byte is available only when `SampleEmpty`=0.
- DATA issue: `SampleRead`=1 in the same cycle `SampleData` is captured into `TxData`. Data stays in DATA until the sample counter reaches `PKT_LEN`.
- Checksum arithmetic:
  - 8-bit accumulator, cleared on leaving IDLE.
  - Adds the length byte and every sample, modulo 256.
  - Checksum byte = two's complement of the accumulator, so the mod-256 sum of length + samples + checksum is 0. The header is excluded.
- `Streaming` is high in every state except IDLE.
- FIFO empty during DATA: the block stalls in ISSUE. No `TxValid`, no `SampleRead`, and `Streaming` stays high. There is no timeout.
- Trigger handling:
  - `Trigger` in IDLE starts a packet and clears `Overrun`.
  - `Trigger` in any other state is dropped and sets `Overrun`.
- Reset asserted mid-packet: all outputs clear immediately. The partial packet is abandoned and any samples already consumed are lost.

## Timing
- Reset values:
  - `TxData`=0, `TxValid`=0, `Streaming`=0, `SampleRead`=0, `PacketDone`=0, `Overrun`=0.
  - FSM in IDLE; sample counter and accumulator cleared.
- `Trigger` sampled high at edge N → `Streaming`=1 from cycle N+1.
- The header `TxValid` occurs at cycle N+2 if `TxStrobe`=1 during N+1.
- `TxValid` is never high on two consecutive cycles. There is at least one observed `TxStrobe`=0 between successive `TxValid` pulses.
- `PacketDone` pulses in the cycle the FSM returns to IDLE. `Streaming` falls on the same edge.
- `TxStrobe`=0 on entry to a packet (a general UART byte still in flight) simply delays the header issue.
- Minimum per-byte overhead is 3 cycles plus the UART frame time.

## Configuration
- Macro `ADC_FRAMER_CHECKSUM_EN`.
- Defined: the CHECKSUM state and accumulator are built; packet length on the wire is `PKT_LEN`+3 bytes.
- Undefined: no accumulator and no CHECKSUM state; packet length on the wire is `PKT_LEN`+2 bytes.

## Structure
- Package `adc_framer_pkg` holds:
  - the main-state enum (IDLE, HEADER, LENGTH, DATA, CHECKSUM);
  - the handshake-phase enum (ISSUE, WAIT_BUSY, WAIT_IDLE);
  - the default header constant 8'hA5.
- One sub-module, `tx_byte_handshake`:
  - owns the ISSUE / WAIT_BUSY / WAIT_IDLE phases and the `TxValid` / `TxData` registers;
  - takes a byte plus a request and returns a one-cycle `accepted` and a `done`.
- The top level holds the main FSM, sample counter, accumulator, `Overrun` and `PacketDone`.

## Test plan
- **Basic packet:** checksum enabled, `PKT_LEN`=4, FIFO preloaded 01 02 03 04, UART model with busy 10 cycles → wire bytes A5 04 01 02 03 04 F2, exactly 4 `SampleRead` pulses, one `PacketDone`.
- **Checksum disabled:** same stimulus → A5 04 01 02 03 04; `Streaming` low the cycle after `PacketDone`.
- **Mid-packet stall:** FIFO empties after 2 samples for 50 cycles → no `TxValid` and `Streaming` held high during the stall, then 03 04 F2 resume correctly.
- **Trigger during DATA:** → `Overrun`=1 and only one packet sent; the next accepted `Trigger` clears `Overrun`.
- **Reset in LENGTH phase:** all outputs 0 on the next sample, FSM in IDLE; a fresh `Trigger` produces a complete packet.
- **UART already busy at trigger:** `TxStrobe` low for 20 cycles after `Trigger` → header `TxValid` is not issued until the first cycle after `TxStrobe` rises.
